// File: rtl/pcie_dllp_rx_decoder_pkg.sv
// Shared PCIe DLL definitions used by the DLLP receive decoder and the CRC-16 block.
// Holds DLLP type constants, FC type / FC-init state enums, DLLP body layouts and
// the DLLP CRC-16 polynomial.
package pcie_dllp_rx_decoder_pkg;

  localparam int unsigned PCIE_DLLP_PACKET_SIZE = 48;

  localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
  localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

  // FC DLLP type nibble is {kind, fc_type}; kind occupies the upper two bits.
  localparam logic [1:0] DLLP_FC_INITFC1  = 2'b01;
  localparam logic [1:0] DLLP_FC_INITFC2  = 2'b11;
  localparam logic [1:0] DLLP_FC_UPDATEFC = 2'b10;

  localparam logic [15:0] DLLP_CRC16_POLY = 16'h100B;
  localparam logic [15:0] DLLP_CRC16_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_type_e;

  typedef enum logic [1:0] {
    FC_INIT1 = 2'd0,
    FC_INIT2 = 2'd1,
    FC_DONE  = 2'd2
  } fc_state_e;

  // InitFC1/InitFC2/UpdateFC body, bits [31:0].
  typedef struct packed {
    logic [3:0]  type_hi;
    logic        z;
    logic [2:0]  vc;
    logic [1:0]  rsvd0;
    logic [7:0]  hdr_fc;
    logic [1:0]  rsvd1;
    logic [11:0] data_fc;
  } dllp_fc_t;

  // Ack/Nak body, bits [31:0].
  typedef struct packed {
    logic [7:0]  dtype;
    logic [11:0] rsvd;
    logic [11:0] seq;
  } dllp_ack_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/pcie_dllp_crc16.sv
// PCIe DLLP CRC-16, purely combinational. Shared with the DLL TX DLLP generator.
// Ports:
//   i_data  32-bit DLLP body, byte 0 in [31:24]
//   o_crc   16-bit CRC as carried in DLLP bits [47:32]
// Bytes are consumed byte 0 first, each LSB first, through a 100Bh LFSR seeded
// with all-ones; the remainder is inverted and each byte is bit-reversed.
module pcie_dllp_crc16
  import pcie_dllp_rx_decoder_pkg::*;
(
  input  logic [31:0] i_data,
  output logic [15:0] o_crc
);

  logic [15:0] w_lfsr;

  always_comb begin
    w_lfsr = DLLP_CRC16_SEED;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        if (w_lfsr[15] ^ i_data[24 - 8*b + i]) begin
          w_lfsr = {w_lfsr[14:0], 1'b0} ^ DLLP_CRC16_POLY;
        end else begin
          w_lfsr = {w_lfsr[14:0], 1'b0};
        end
      end
    end
  end

  assign o_crc = {bitrev8(~w_lfsr[15:8]), bitrev8(~w_lfsr[7:0])};

endmodule

// File: rtl/pcie_dllp_rx_decoder.sv
// Receive-side DLLP decoder: CRC check, Ack/Nak forwarding, per-VC FC init FSM
// and credit-limit registers.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_link_up               DL_Up; low returns every VC to FC_INIT1
//   i_dllp_valid/_data      incoming DLLP, [47:32] CRC, [31:0] body
//   o_ack_valid/_is_nak/_seq  decoded Ack/Nak pulse
//   o_fc_init_done          per-VC FC_DONE flag
//   o_fc_hdr_limit/_data_limit  credit limits, index (vc*3+type)
//   o_fc_update             per-VC pulse on any limit write
//   o_crc_err_cnt/o_unsup_cnt  saturating error counters
module pcie_dllp_rx_decoder
  import pcie_dllp_rx_decoder_pkg::*;
#(
  parameter int unsigned NUM_VC    = 1,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_link_up,
  input  logic                        i_dllp_valid,
  input  logic [47:0]                 i_dllp_data,
  output logic                        o_ack_valid,
  output logic                        o_ack_is_nak,
  output logic [11:0]                 o_ack_seq,
  output logic [NUM_VC-1:0]           o_fc_init_done,
  output logic [NUM_VC*3*8-1:0]       o_fc_hdr_limit,
  output logic [NUM_VC*3*12-1:0]      o_fc_data_limit,
  output logic [NUM_VC-1:0]           o_fc_update,
  output logic [ERR_CNT_W-1:0]        o_crc_err_cnt,
  output logic [ERR_CNT_W-1:0]        o_unsup_cnt
);

  logic                 r_s1_valid, r_s2_valid, r_s2_crc_ok;
  logic [47:0]          r_s1_data;
  logic [31:0]          r_s2_body;
  logic [15:0]          w_crc;
  logic                 r_ack_valid, r_ack_is_nak;
  logic [11:0]          r_ack_seq;
  logic [ERR_CNT_W-1:0] r_crc_err_cnt, r_unsup_cnt;

  pcie_dllp_crc16 u_crc (
    .i_data (r_s1_data[31:0]),
    .o_crc  (w_crc)
  );

  // CRC is evaluated on stage 1 and carried as a flag; decode happens on stage 2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_crc_ok <= 1'b0;
      r_s2_body   <= '0;
    end else begin
      r_s1_valid  <= i_dllp_valid;
      r_s1_data   <= i_dllp_data;
      r_s2_valid  <= r_s1_valid;
      r_s2_crc_ok <= (w_crc == r_s1_data[47:32]);
      r_s2_body   <= r_s1_data[31:0];
    end
  end

  dllp_fc_t  w_fc;
  dllp_ack_t w_ack;
  logic      w_good, w_is_ack, w_fc_known, w_vc_ok, w_fc_valid, w_unsup;
  logic [1:0] w_kind;
  fc_type_e  w_fct;
  logic      w_unused;

  assign w_fc       = r_s2_body;
  assign w_ack      = r_s2_body;
  assign w_kind     = w_fc.type_hi[3:2];
  assign w_fct      = fc_type_e'(w_fc.type_hi[1:0]);
  assign w_good     = r_s2_valid && r_s2_crc_ok;
  assign w_is_ack   = w_good && (w_ack.dtype == DLLP_TYPE_ACK || w_ack.dtype == DLLP_TYPE_NAK);
  assign w_fc_known = (w_kind != 2'b00) && (w_fc.type_hi[1:0] != 2'b11);
  assign w_vc_ok    = ({29'd0, w_fc.vc} < NUM_VC);
  assign w_fc_valid = w_good && !w_is_ack && w_fc_known && !w_fc.z && w_vc_ok;
  assign w_unsup    = w_good && !w_is_ack && !(w_fc_known && !w_fc.z && w_vc_ok);
  assign w_unused   = ^{w_fc.rsvd0, w_fc.rsvd1, w_ack.rsvd};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack_valid   <= 1'b0;
      r_ack_is_nak  <= 1'b0;
      r_ack_seq     <= '0;
      r_crc_err_cnt <= '0;
      r_unsup_cnt   <= '0;
    end else begin
      r_ack_valid <= w_is_ack;
      if (w_is_ack) begin
        r_ack_is_nak <= (w_ack.dtype == DLLP_TYPE_NAK);
        r_ack_seq    <= w_ack.seq;
      end
      if (r_s2_valid && !r_s2_crc_ok && r_crc_err_cnt != '1) begin
        r_crc_err_cnt <= r_crc_err_cnt + 1'b1;
      end
      if (w_unsup && r_unsup_cnt != '1) begin
        r_unsup_cnt <= r_unsup_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    fc_state_e   r_state, w_state_next;
    logic [2:0]  r_seen, w_seen_next;
    logic        w_hit, w_wr, r_update;
    logic [7:0]  r_hdr  [3];
    logic [11:0] r_data [3];

    assign w_hit = w_fc_valid && (w_fc.vc == 3'(g));

    // link_up low wins over any FC DLLP in stage 2: no limit write happens.
    always_comb begin
      w_state_next = r_state;
      w_seen_next  = r_seen;
      w_wr         = 1'b0;
      if (!i_link_up) begin
        w_state_next = FC_INIT1;
        w_seen_next  = '0;
      end else begin
        case (r_state)
          FC_INIT1: begin
            if (w_hit && w_kind == DLLP_FC_INITFC1) begin
              w_wr        = 1'b1;
              w_seen_next = r_seen | (3'b001 << w_fct);
            end
            // All three types seen on an earlier edge: advance now.
            if (&r_seen) begin
              w_state_next = FC_INIT2;
              w_seen_next  = '0;
            end
          end
          FC_INIT2: begin
            if (w_hit) begin
              w_wr = 1'b1;
              if (w_kind != DLLP_FC_INITFC1) w_state_next = FC_DONE;
            end
          end
          FC_DONE: begin
            if (w_hit && w_kind == DLLP_FC_UPDATEFC) w_wr = 1'b1;
          end
          default: w_state_next = FC_INIT1;
        endcase
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state  <= FC_INIT1;
        r_seen   <= '0;
        r_update <= 1'b0;
        for (int t = 0; t < 3; t++) begin
          r_hdr[t]  <= '0;
          r_data[t] <= '0;
        end
      end else begin
        r_state  <= w_state_next;
        r_seen   <= w_seen_next;
        r_update <= w_wr;
        for (int t = 0; t < 3; t++) begin
          if (w_wr && int'(w_fct) == t) begin
            r_hdr[t]  <= w_fc.hdr_fc;
            r_data[t] <= w_fc.data_fc;
          end
        end
      end
    end

    for (genvar t = 0; t < 3; t++) begin : g_type
      assign o_fc_hdr_limit[(g*3+t)*8 +: 8]   = r_hdr[t];
      assign o_fc_data_limit[(g*3+t)*12 +: 12] = r_data[t];
    end

    assign o_fc_init_done[g] = (r_state == FC_DONE);
    assign o_fc_update[g]    = r_update;
  end

  assign o_ack_valid   = r_ack_valid;
  assign o_ack_is_nak  = r_ack_is_nak;
  assign o_ack_seq     = r_ack_seq;
  assign o_crc_err_cnt = r_crc_err_cnt;
  assign o_unsup_cnt   = r_unsup_cnt;

endmodule

// File: tb/tb_pcie_dllp_rx_decoder.sv
// Self-checking bench for pcie_dllp_rx_decoder (NUM_VC=2, narrow counters).
// A transaction-level model advances once per clock on the DLLP that entered two
// cycles earlier; a monitor compares every output each cycle. Directed phases
// pin the model with literal values, then a randomized phase follows.
module tb_pcie_dllp_rx_decoder;

  localparam int NUM_VC  = 2;
  localparam int ERR_W   = 5;
  localparam int CNT_MAX = (1 << ERR_W) - 1;
  localparam int ST_INIT1 = 0;
  localparam int ST_INIT2 = 1;
  localparam int ST_DONE  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n, link_up, dllp_valid;
  logic [47:0]            dllp_data;
  logic                   o_ack_valid, o_ack_is_nak;
  logic [11:0]            o_ack_seq;
  logic [NUM_VC-1:0]      o_fc_init_done, o_fc_update;
  logic [NUM_VC*24-1:0]   o_fc_hdr_limit;
  logic [NUM_VC*36-1:0]   o_fc_data_limit;
  logic [ERR_W-1:0]       o_crc_err_cnt, o_unsup_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  pcie_dllp_rx_decoder #(
    .NUM_VC    (NUM_VC),
    .ERR_CNT_W (ERR_W)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_link_up       (link_up),
    .i_dllp_valid    (dllp_valid),
    .i_dllp_data     (dllp_data),
    .o_ack_valid     (o_ack_valid),
    .o_ack_is_nak    (o_ack_is_nak),
    .o_ack_seq       (o_ack_seq),
    .o_fc_init_done  (o_fc_init_done),
    .o_fc_hdr_limit  (o_fc_hdr_limit),
    .o_fc_data_limit (o_fc_data_limit),
    .o_fc_update     (o_fc_update),
    .o_crc_err_cnt   (o_crc_err_cnt),
    .o_unsup_cnt     (o_unsup_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-serial CRC written from the definition: stream bytes 0..3 LSB first.
  function automatic logic [15:0] ref_crc(input logic [31:0] body);
    logic [15:0] r;
    logic [15:0] out;
    bit q[$];
    bit top;
    r = 16'hFFFF;
    for (int b = 3; b >= 0; b--) for (int i = 0; i < 8; i++) q.push_back(body[8*b+i]);
    foreach (q[k]) begin
      top = r[15] ^ q[k];
      r = {r[14:0], 1'b0};
      if (top) r = r ^ 16'h100B;
    end
    r = ~r;
    for (int i = 0; i < 8; i++) begin
      out[15-i] = r[8+i];
      out[7-i]  = r[i];
    end
    return out;
  endfunction

  function automatic logic [31:0] fc_body(input logic [3:0] hi, input logic [2:0] vc,
                                          input logic [7:0] hdr, input logic [11:0] dat);
    return {hi, 1'b0, vc, 2'b00, hdr, 2'b00, dat};
  endfunction

  // ---------------- behavioural model ----------------
  int           m_state [NUM_VC];
  bit   [2:0]   m_seen  [NUM_VC];
  logic [7:0]   m_hdr   [NUM_VC][3];
  logic [11:0]  m_dat   [NUM_VC][3];
  bit           m_upd   [NUM_VC];
  bit           m_ackv, m_nak;
  logic [11:0]  m_seq;
  int           m_crc_cnt, m_unsup;
  bit           p_v [2];
  logic [47:0]  p_d [2];

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) begin
      m_state[v] = ST_INIT1;
      m_seen[v]  = '0;
      m_upd[v]   = 0;
      for (int t = 0; t < 3; t++) begin
        m_hdr[v][t] = '0;
        m_dat[v][t] = '0;
      end
    end
    m_ackv = 0; m_nak = 0; m_seq = '0; m_crc_cnt = 0; m_unsup = 0;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 0;
      p_d[i] = '0;
    end
  endtask

  task automatic model_step(input bit v, input logic [47:0] d, input bit lu);
    bit ev, ready, hit, wr;
    int evc, kind, ft, hi;
    ev = 0; evc = 0; kind = 0; ft = 0;
    m_ackv = 0;
    for (int i = 0; i < NUM_VC; i++) m_upd[i] = 0;
    if (v) begin
      if (d[47:32] != ref_crc(d[31:0])) begin
        if (m_crc_cnt < CNT_MAX) m_crc_cnt++;
      end else if (d[31:24] == 8'h00 || d[31:24] == 8'h10) begin
        m_ackv = 1;
        m_nak  = (d[31:24] == 8'h10);
        m_seq  = d[11:0];
      end else begin
        hi = int'(d[31:28]);
        if (hi >= 4 && hi <= 6) begin kind = 1; ft = hi - 4; end
        else if (hi >= 12 && hi <= 14) begin kind = 2; ft = hi - 12; end
        else if (hi >= 8 && hi <= 10) begin kind = 3; ft = hi - 8; end
        evc = int'(d[26:24]);
        if (kind == 0 || d[27] || evc >= NUM_VC) begin
          if (m_unsup < CNT_MAX) m_unsup++;
        end else begin
          ev = 1;
        end
      end
    end
    for (int vc = 0; vc < NUM_VC; vc++) begin
      if (!lu) begin
        m_state[vc] = ST_INIT1;
        m_seen[vc]  = '0;
      end else begin
        wr    = 0;
        ready = (m_seen[vc] == 3'b111);
        hit   = ev && (evc == vc);
        if (m_state[vc] == ST_INIT1) begin
          if (hit && kind == 1) begin wr = 1; m_seen[vc][ft] = 1'b1; end
          if (ready) begin m_state[vc] = ST_INIT2; m_seen[vc] = '0; end
        end else if (m_state[vc] == ST_INIT2) begin
          if (hit) begin
            wr = 1;
            if (kind != 1) m_state[vc] = ST_DONE;
          end
        end else begin
          if (hit && kind == 3) wr = 1;
        end
        if (wr) begin
          m_hdr[vc][ft] = d[21:14];
          m_dat[vc][ft] = d[11:0];
          m_upd[vc]     = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_VC*24-1:0] eh;
    logic [NUM_VC*36-1:0] ed;
    logic [NUM_VC-1:0]    edone, eupd;
    for (int v = 0; v < NUM_VC; v++) begin
      edone[v] = (m_state[v] == ST_DONE);
      eupd[v]  = m_upd[v];
      for (int t = 0; t < 3; t++) begin
        eh[(v*3+t)*8 +: 8]   = m_hdr[v][t];
        ed[(v*3+t)*12 +: 12] = m_dat[v][t];
      end
    end
    check("ack_valid",  128'(o_ack_valid),     128'(m_ackv));
    check("ack_is_nak", 128'(o_ack_is_nak),    128'(m_nak));
    check("ack_seq",    128'(o_ack_seq),       128'(m_seq));
    check("init_done",  128'(o_fc_init_done),  128'(edone));
    check("hdr_limit",  128'(o_fc_hdr_limit),  128'(eh));
    check("data_limit", 128'(o_fc_data_limit), 128'(ed));
    check("fc_update",  128'(o_fc_update),     128'(eupd));
    check("crc_err",    128'(o_crc_err_cnt),   128'(m_crc_cnt));
    check("unsup",      128'(o_unsup_cnt),     128'(m_unsup));
  endtask

  // Inputs change on negedges, so values read here are those the DUT samples.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(p_v[1], p_d[1], link_up);
      p_v[1] = p_v[0];
      p_d[1] = p_d[0];
      p_v[0] = dllp_valid;
      p_d[0] = dllp_data;
    end
    #1;
    compare_all();
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      dllp_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] body, input bit bad = 1'b0);
    logic [15:0] c;
    @(negedge clk);
    c = ref_crc(body);
    if (bad) c[0] = ~c[0];
    dllp_valid = 1'b1;
    dllp_data  = {c, body};
  endtask

  function automatic logic [31:0] rand_body();
    int r;
    logic [3:0] his [9];
    logic [2:0] vc;
    his = '{4'h4, 4'h5, 4'h6, 4'hC, 4'hD, 4'hE, 4'h8, 4'h9, 4'hA};
    r = int'($urandom_range(0, 99));
    if (r < 20) begin
      return {($urandom_range(0, 1) != 0) ? 8'h10 : 8'h00, 12'($urandom), 12'($urandom)};
    end else if (r < 90) begin
      vc = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
      return {his[$urandom_range(0, 8)], ($urandom_range(0, 19) == 0), vc,
              2'($urandom), 8'($urandom), 2'($urandom), 12'($urandom)};
    end
    return $urandom;
  endfunction

  initial begin
    logic [31:0] body;
    logic [15:0] c;
    rst_n = 1'b0; link_up = 1'b1; dllp_valid = 1'b0; dllp_data = '0;
    tick(3);
    check("rst_init_done", 128'(o_fc_init_done), 128'(0));
    check("rst_crc_cnt",   128'(o_crc_err_cnt),  128'(0));
    check("rst_hdr",       128'(o_fc_hdr_limit), 128'(0));
    rst_n = 1'b1;

    // Ack 0x123 then Nak 0xFFF back to back.
    send({8'h00, 12'h000, 12'h123});
    send({8'h10, 12'h000, 12'hFFF});
    tick(2);
    check("ack1_valid", 128'(o_ack_valid),  128'(1));
    check("ack1_nak",   128'(o_ack_is_nak), 128'(0));
    check("ack1_seq",   128'(o_ack_seq),    128'(12'h123));
    tick();
    check("nak_valid",  128'(o_ack_valid),  128'(1));
    check("nak_nak",    128'(o_ack_is_nak), 128'(1));
    check("nak_seq",    128'(o_ack_seq),    128'(12'hFFF));
    tick();
    check("ack_idle",   128'(o_ack_valid),  128'(0));

    // VC1 InitFC1 P/NP/Cpl, then InitFC2-P after the INIT2 transition.
    send(fc_body(4'h4, 3'd1, 8'h20, 12'h400));
    send(fc_body(4'h5, 3'd1, 8'h10, 12'h000));
    send(fc_body(4'h6, 3'd1, 8'h00, 12'h000));
    tick();
    send(fc_body(4'hC, 3'd1, 8'h20, 12'h400));
    tick(3);
    check("vc1_done",     128'(o_fc_init_done), 128'(2'b10));
    check("vc1_hdr_p",    128'(o_fc_hdr_limit[(1*3+0)*8 +: 8]),  128'(8'h20));
    check("vc1_hdr_np",   128'(o_fc_hdr_limit[(1*3+1)*8 +: 8]),  128'(8'h10));
    check("vc1_hdr_cpl",  128'(o_fc_hdr_limit[(1*3+2)*8 +: 8]),  128'(8'h00));
    check("vc1_data_p",   128'(o_fc_data_limit[(1*3+0)*12 +: 12]), 128'(12'h400));
    check("vc1_data_np",  128'(o_fc_data_limit[(1*3+1)*12 +: 12]), 128'(12'h000));
    check("vc1_update",   128'(o_fc_update),    128'(2'b10));

    // Bring VC0 to FC_DONE, then UpdateFC-NP hdr 0x05.
    send(fc_body(4'h4, 3'd0, 8'h08, 12'h040));
    send(fc_body(4'h5, 3'd0, 8'h04, 12'h020));
    send(fc_body(4'h6, 3'd0, 8'h02, 12'h010));
    tick();
    send(fc_body(4'hC, 3'd0, 8'h08, 12'h040));
    tick(3);
    check("both_done",  128'(o_fc_init_done), 128'(2'b11));
    send(fc_body(4'h9, 3'd0, 8'h05, 12'h0AB));
    tick(3);
    check("vc0_upd_np", 128'(o_fc_hdr_limit[(0*3+1)*8 +: 8]), 128'(8'h05));
    check("vc0_upd_pulse", 128'(o_fc_update), 128'(2'b01));
    tick();
    check("vc0_upd_once",  128'(o_fc_update), 128'(2'b00));

    // Bad CRC, then counter saturation.
    send(fc_body(4'h4, 3'd0, 8'h33, 12'h333), 1'b1);
    tick(3);
    check("crc_cnt_1",   128'(o_crc_err_cnt), 128'(1));
    check("crc_no_write", 128'(o_fc_hdr_limit[(0*3+0)*8 +: 8]), 128'(8'h08));
    for (int i = 0; i < (1 << ERR_W) + 3; i++) send(fc_body(4'h4, 3'd0, 8'h33, 12'h333), 1'b1);
    tick(3);
    check("crc_cnt_sat", 128'(o_crc_err_cnt), 128'(5'h1F));

    // Unsupported: vc_id 5, then unknown type 0x31.
    send(fc_body(4'h8, 3'd5, 8'h44, 12'h444));
    send({8'h31, 24'h000000});
    tick(3);
    check("unsup_cnt",  128'(o_unsup_cnt),    128'(2));
    check("unsup_keep", 128'(o_fc_init_done), 128'(2'b11));

    // link_up low while an UpdateFC for VC1 sits in stage 2.
    send(fc_body(4'h8, 3'd1, 8'h77, 12'h777));
    tick();
    tick();
    link_up = 1'b0;
    tick();
    link_up = 1'b1;
    check("lu_init_done", 128'(o_fc_init_done), 128'(0));
    check("lu_hdr_keep",  128'(o_fc_hdr_limit[(1*3+0)*8 +: 8]), 128'(8'h20));
    check("lu_no_update", 128'(o_fc_update), 128'(0));

    // Reset with DLLPs in flight.
    send({8'h00, 12'h000, 12'h055});
    send(fc_body(4'h4, 3'd0, 8'h11, 12'h111));
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_ack",  128'(o_ack_valid),     128'(0));
    check("mid_rst_seq",  128'(o_ack_seq),       128'(0));
    check("mid_rst_hdr",  128'(o_fc_hdr_limit),  128'(0));
    check("mid_rst_data", 128'(o_fc_data_limit), 128'(0));
    check("mid_rst_cnt",  128'(o_crc_err_cnt),   128'(0));
    check("mid_rst_uns",  128'(o_unsup_cnt),     128'(0));
    rst_n = 1'b1;
    tick(4);

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      link_up = ($urandom_range(0, 99) != 0);
      if (cyc == 2000) rst_n = 1'b0;
      if (cyc == 2002) rst_n = 1'b1;
      dllp_valid = ($urandom_range(0, 9) < 8);
      body = rand_body();
      c = ref_crc(body);
      if ($urandom_range(0, 11) == 0) c = c ^ (16'h0001 << $urandom_range(0, 15));
      dllp_data = {c, body};
    end
    link_up = 1'b1;
    tick(5);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
